// File: rtl/clock_gen_pkg.sv
// clock_gen_pkg: shared phase types, one-hot constants and decode helper for clock_gen
package clock_gen_pkg;
  localparam int NUM_PHASES = 4;
  typedef logic [1:0] phase_t;
  localparam logic [NUM_PHASES-1:0] PH1_OH = 4'b0001;
  localparam logic [NUM_PHASES-1:0] PH2_OH = 4'b0010;
  localparam logic [NUM_PHASES-1:0] PH3_OH = 4'b0100;
  localparam logic [NUM_PHASES-1:0] PH4_OH = 4'b1000;
  function automatic phase_t oh2idx(input logic [NUM_PHASES-1:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction
endpackage

// File: rtl/clock_gen_rst_sync.sv
// clock_gen_rst_sync: 2-flop reset synchroniser, asynchronous assert, synchronous deassert
module clock_gen_rst_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_rst_n
);
  logic [1:0] r_sync;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_sync <= '0;
    else r_sync <= {r_sync[0], 1'b1};
  assign o_rst_n = r_sync[1];
endmodule

// File: rtl/clock_gen.sv
// clock_gen: four-phase non-overlapping clock generator, each phase high DIV clk12 cycles
// Define CLOCKGEN_SAFE_EN to add the one-hot ring checker with sticky phase_err and forced recovery.
module clock_gen #(
  parameter int DIV = 1
) (
  input  logic       clk12,
  input  logic       rst_n,
  output logic       phi1,
  output logic       phi2,
  output logic       phi3,
  output logic       phi4,
  output logic [1:0] phase,
  output logic       cycle_start,
  output logic       phase_err
);
  import clock_gen_pkg::*;
  localparam int CW = $clog2(DIV) + 1;
  logic                  w_run;
  logic                  w_wrap;
  logic                  w_bad;
  logic                  w_cs_nxt;
  logic [NUM_PHASES-1:0] w_rot;
  logic [NUM_PHASES-1:0] w_ring_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [NUM_PHASES-1:0] r_ring;
  logic [CW-1:0]         r_cnt;
  phase_t                r_phase;
  logic                  r_cs;
  logic                  r_live;
  clock_gen_rst_sync u_rst_sync (
    .i_clk   (clk12),
    .i_rst_n (rst_n),
    .o_rst_n (w_run)
  );
  assign w_wrap = r_cnt == CW'(DIV - 1);
  assign w_rot  = {r_ring[NUM_PHASES-2:0], r_ring[NUM_PHASES-1]};
`ifdef CLOCKGEN_SAFE_EN
  logic r_err;
  assign w_bad = r_live && !$onehot(r_ring);
  always_ff @(posedge clk12 or negedge rst_n)
    if (!rst_n) r_err <= 1'b0;
    else if (w_bad) r_err <= 1'b1;
  assign phase_err = r_err;
`else
  assign w_bad     = 1'b0;
  assign phase_err = 1'b0;
`endif
  // the first live edge and a detected fault both (re)start at phi1 with a full window
  always_comb begin
    w_ring_nxt = (!r_live || w_bad) ? PH1_OH : w_wrap ? w_rot : r_ring;
    w_cnt_nxt  = (!r_live || w_bad || w_wrap) ? '0 : r_cnt + 1'b1;
    w_cs_nxt   = w_ring_nxt[0] && (!r_live || w_bad || !r_ring[0]);
  end
  always_ff @(posedge clk12 or negedge rst_n)
    if (!rst_n) begin
      r_live  <= 1'b0;
      r_ring  <= '0;
      r_cnt   <= '0;
      r_phase <= '0;
      r_cs    <= 1'b0;
    end else if (w_run) begin
      r_live  <= 1'b1;
      r_ring  <= w_ring_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= oh2idx(w_ring_nxt);
      r_cs    <= w_cs_nxt;
    end
  assign phi1        = r_ring[0];
  assign phi2        = r_ring[1];
  assign phi3        = r_ring[2];
  assign phi4        = r_ring[3];
  assign phase       = r_phase;
  assign cycle_start = r_cs;
endmodule

// File: tb/tb_clock_gen.sv
// tb_clock_gen: scoreboard bench for clock_gen at DIV=1 and DIV=3
module tb_clock_gen;
  import clock_gen_pkg::*;
  typedef struct {
    logic [3:0] phi;
    logic [1:0] ph;
    logic       cs;
    logic       err;
    logic       lax;
  } exp_t;
  logic       clk12 = 1'b0;
  logic       rst_n = 1'b0;
  logic       p1_1, p2_1, p3_1, p4_1, cs_1, err_1;
  logic       p1_3, p2_3, p3_3, p4_3, cs_3, err_3;
  logic [1:0] ph_1, ph_3;
  exp_t       q1[$];
  exp_t       q3[$];
  int         n_vec = 0;
  int         n_bad = 0;
  clock_gen #(.DIV(1)) u_d1 (
    .clk12(clk12), .rst_n(rst_n), .phi1(p1_1), .phi2(p2_1), .phi3(p3_1), .phi4(p4_1),
    .phase(ph_1), .cycle_start(cs_1), .phase_err(err_1)
  );
  clock_gen #(.DIV(3)) u_d3 (
    .clk12(clk12), .rst_n(rst_n), .phi1(p1_3), .phi2(p2_3), .phi3(p3_3), .phi4(p4_3),
    .phase(ph_3), .cycle_start(cs_3), .phase_err(err_3)
  );
  always #5 clk12 = ~clk12;
  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask
  task automatic check(input string tag, input exp_t e, input logic [3:0] phi,
                       input logic [1:0] ph, input logic cs, input logic err);
    cmp({tag, " phi"}, 8'(phi), 8'(e.phi));
    cmp({tag, " err"}, 8'(err), 8'(e.err));
    if (!e.lax) begin
      cmp({tag, " phase"}, 8'(ph), 8'(e.ph));
      cmp({tag, " cycle_start"}, 8'(cs), 8'(e.cs));
      if (e.phi != 4'b0) begin
        cmp({tag, " onehot"}, 8'($onehot(phi)), 8'd1);
        cmp({tag, " phase_dec"}, 8'(ph), 8'(oh2idx(phi)));
      end
    end
  endtask
  task automatic push(input int d, input int nz, input int n, input logic err, input logic lax0);
    exp_t e;
    for (int k = 0; k < nz; k++) begin
      e = '{4'b0, 2'd0, 1'b0, 1'b0, 1'b0};
      if (d == 1) q1.push_back(e); else q3.push_back(e);
    end
    for (int m = 0; m < n; m++) begin
      int idx;
      idx = (m / d) % 4;
      e.phi = 4'(1 << idx);
      e.ph  = 2'(idx);
      e.cs  = (m % (4 * d)) == 0;
      e.err = err;
      e.lax = (m == 0) && lax0;
      if (d == 1) q1.push_back(e); else q3.push_back(e);
    end
  endtask
  task automatic drain();
    int t;
    t = 0;
    while ((q1.size() != 0 || q3.size() != 0) && t < 1000) begin
      @(negedge clk12);
      t++;
    end
    cmp("drain timeout", 8'(q1.size() + q3.size()), 8'd0);
  endtask
  always @(negedge clk12) begin
    exp_t e;
    if (q1.size() != 0) begin
      e = q1.pop_front();
      check("div1", e, {p4_1, p3_1, p2_1, p1_1}, ph_1, cs_1, err_1);
    end
    if (q3.size() != 0) begin
      e = q3.pop_front();
      check("div3", e, {p4_3, p3_3, p2_3, p1_3}, ph_3, cs_3, err_3);
    end
  end
  initial begin
    int t;
    exp_t e;
    push(1, 4, 200, 1'b0, 1'b0);
    push(3, 4, 200, 1'b0, 1'b0);
    #20 rst_n = 1'b1;
    drain();
    t = 0;
    while (!p3_1 && t < 20) begin
      @(negedge clk12);
      t++;
    end
    cmp("wait phi3", 8'(p3_1), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    cmp("async drop div1", 8'({p4_1, p3_1, p2_1, p1_1, ph_1, cs_1}), 8'd0);
    cmp("async drop div3", 8'({p4_3, p3_3, p2_3, p1_3, ph_3, cs_3}), 8'd0);
    @(negedge clk12);
    @(negedge clk12);
    rst_n = 1'b1;
    #2;
    push(1, 2, 24, 1'b0, 1'b0);
    push(3, 2, 24, 1'b0, 1'b0);
    drain();
    #1 force u_d1.r_ring = 4'b0101;
    #3 release u_d1.r_ring;
`ifdef CLOCKGEN_SAFE_EN
    push(1, 0, 12, 1'b1, 1'b1);
`else
    for (int m = 0; m < 8; m++) begin
      e = '{(m % 2 == 0) ? 4'b1010 : 4'b0101, 2'd0, 1'b0, 1'b0, 1'b1};
      q1.push_back(e);
    end
`endif
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1);
  end
endmodule
